// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with whole-scan debounce
module keypad_scanner #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyRow,
  output logic [3:0] keyCol,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [DW-1:0] div_q;
  logic [1:0]    col_q;
  logic [3:0]    row_meta_q, row_sync_q;
  logic          snap_hit_q;
  logic [3:0]    snap_code_q;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

  logic          tick;
  logic          scan_end;
  logic          samp_hit;
  logic [1:0]    samp_row;
  logic          eval_hit;
  logic [3:0]    eval_code;
  logic [CW-1:0] cnt_inc;

  assign tick     = (div_q == DIV_LAST);
  assign scan_end = tick && (col_q == 2'd3);
  assign cnt_inc  = cnt_q + CW'(1);

  // Tick divider and column counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      col_q <= 2'd0;
    end else if (tick) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs; idle rows read high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= keyRow;
      row_sync_q <= row_meta_q;
    end
  end

  // Lowest active-low row in the current column sample
  always_comb begin
    samp_hit = ~&row_sync_q;
    samp_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) samp_row = 2'(i);
    end
  end

  // Snapshot seen by the FSM folds in the column-3 sample taken at scan end
  always_comb begin
    eval_hit  = snap_hit_q | samp_hit;
    eval_code = snap_hit_q ? snap_code_q : {samp_row, col_q};
  end

  // Per-scan snapshot: first hit wins, cleared at every scan end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_hit_q  <= 1'b0;
      snap_code_q <= 4'd0;
    end else if (scan_end) begin
      snap_hit_q  <= 1'b0;
      snap_code_q <= 4'd0;
    end else if (tick && !snap_hit_q && samp_hit) begin
      snap_hit_q  <= 1'b1;
      snap_code_q <= {samp_row, col_q};
    end
  end

  // Debounce FSM state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  // Debounce FSM next state; only moves on a scan-end tick
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (eval_hit) begin
            state_d = PRESS_WAIT;
            cand_d  = eval_code;
            cnt_d   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!eval_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (eval_code != cand_q) begin
            cand_d = eval_code;
            cnt_d  = CW'(1);
          end else if (cnt_inc == CNT_DONE) begin
            state_d = PRESSED;
            cnt_d   = '0;
            code_d  = cand_q;
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          if (!(eval_hit && eval_code == code_q)) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (eval_hit) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // One-hot-low column drive
  always_comb begin
    case (col_q)
      2'd0:    keyCol = 4'b1110;
      2'd1:    keyCol = 4'b1101;
      2'd2:    keyCol = 4'b1011;
      default: keyCol = 4'b0111;
    endcase
  end

  assign keyCode  = code_q;
  assign keyValid = valid_q;
  assign keyHeld  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  localparam int D = 3;

  logic       clk;
  logic       reset;
  logic [3:0] keyRow;
  logic [3:0] keyCol;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;

  logic [15:0] keys;   // bit r*4+c set => key at row r, column c is pressed

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] exp_q[$];

  // reference model state
  bit       m_held;
  int       m_run;
  int       m_rel;
  int       m_cand;
  int       m_code;

  keypad_scanner #(
    .CLK_HZ(4),
    .SCAN_HZ(1),
    .DEBOUNCE_SCANS(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keyRow(keyRow),
    .keyCol(keyCol),
    .keyCode(keyCode),
    .keyValid(keyValid),
    .keyHeld(keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    keyRow = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !keyCol[c]) keyRow[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_held = 0;
    m_run  = 0;
    m_rel  = 0;
    m_cand = 0;
    m_code = 0;
  endtask

  // one full scan evaluated from the set of pressed keys
  task automatic model_scan(input logic [15:0] mask);
    bit hit;
    int code;
    hit  = 0;
    code = 0;
    for (int c = 0; c < 4 && !hit; c++)
      for (int r = 0; r < 4 && !hit; r++)
        if (mask[r*4+c]) begin
          hit  = 1;
          code = r * 4 + c;
        end
    if (!m_held) begin
      if (hit && m_run > 0 && code == m_cand) m_run++;
      else if (hit) begin
        m_run  = 1;
        m_cand = code;
      end else m_run = 0;
      if (m_run == D) begin
        m_held = 1;
        m_code = m_cand;
        m_run  = 0;
        m_rel  = 0;
        exp_q.push_back(4'(m_code));
      end
    end else begin
      if (hit && code == m_code) m_rel = 0;
      else if (!hit) m_rel++;
      else m_rel = (m_rel == 0) ? 1 : 0;
      if (m_rel == D) begin
        m_held = 0;
        m_rel  = 0;
        m_run  = 0;
      end
    end
  endtask

  // called at a scan boundary (#1 after the scan-end edge)
  task automatic do_scan(input logic [15:0] mask);
    keys = mask;
    repeat (16) @(posedge clk);
    #1;
    model_scan(mask);
    check("keyHeld", int'(keyHeld), int'(m_held));
    check("keyCode", int'(keyCode), m_code);
  endtask

  task automatic scans(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) do_scan(mask);
  endtask

  // monitor: every keyValid pulse must match the next expected press
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (reset && keyValid) begin
      if (exp_q.size() == 0) check("unexpected_keyValid", int'(keyCode), -1);
      else check("keyValid_code", int'(keyCode), int'(exp_q.pop_front()));
      if (prev_valid) check("keyValid_double", 1, 0);
    end
    prev_valid <= keyValid;
  end

  initial begin
    keys  = 16'h0;
    reset = 1'b0;
    model_reset();
    // reset state
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_keyCol", int'(keyCol), 4'b1110);
      check("rst_keyValid", int'(keyValid), 0);
      check("rst_keyHeld", int'(keyHeld), 0);
      check("rst_keyCode", int'(keyCode), 0);
    end
    reset = 1'b1;
    // column scan order, 4 cycles per column
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << (i / 4));
      check("scan_keyCol", int'(keyCol), int'(exp_col));
      check("scan_keyValid", int'(keyValid), 0);
      @(posedge clk);
      #1;
    end
    model_scan(16'h0);

    // clean press of key 9 (row 2, col 1)
    scans(16'h0001 << 9, 10);
    // release with one-scan glitch
    do_scan(16'h0);
    do_scan(16'h0001 << 9);
    scans(16'h0, 5);

    // bounce on key 3 (row 0, col 3)
    scans(16'h0001 << 3, 2);
    do_scan(16'h0);
    scans(16'h0001 << 3, 2);
    scans(16'h0, 5);

    // multi-key: 12 (row 3, col 0) and 2 (row 0, col 2)
    scans((16'h0001 << 12) | (16'h0001 << 2), 5);
    scans(16'h0001 << 2, 4);
    scans(16'h0, 4);
    scans(16'h0001 << 2, 4);
    scans(16'h0, 4);

    // reset mid-press
    scans(16'h0001 << 9, 5);
    reset = 1'b0;
    #1;
    check("midrst_keyHeld", int'(keyHeld), 0);
    check("midrst_keyCode", int'(keyCode), 0);
    check("midrst_keyCol", int'(keyCol), 4'b1110);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    scans(16'h0001 << 9, 4);
    scans(16'h0, 4);

    // randomized segments
    for (int s = 0; s < 40; s++) begin
      logic [15:0] m;
      int sel;
      sel = int'($urandom_range(0, 3));
      m = 16'h0;
      if (sel >= 1) m[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) m[$urandom_range(0, 15)] = 1'b1;
      scans(m, int'($urandom_range(1, 5)));
    end
    scans(16'h0, 4);

    repeat (4) @(posedge clk);
    #1;
    check("pending_presses", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one active-low column at a time and reading active-low rows. It debounces the result across whole scans and reports each new key press as a one-cycle strobe carrying a 4-bit key code. It is the input-side counterpart of the multiplexed FND display driver: the same tick-driven 2-bit scan counter and one-hot-low select, but reading instead of writing. It sits beside the FND on the board I/O and feeds a CPU-side APB peripheral.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1_000, column step rate. CLK_HZ/SCAN_HZ must be >= 4.
- DEBOUNCE_SCANS, 4, number of consecutive identical full scans required to accept a press or release. Must be >= 2.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- keyRow  input  4  keypad rows. Active-low, pulled up externally, asynchronous to clk.
- keyCol  output  4  keypad column drive. Exactly one bit is 0 at a time.
- keyCode  output  4  code of the last accepted key: row*4 + col.
- keyValid  output  1  one-cycle strobe when a new press is accepted.
- keyHeld  output  1  high from press acceptance until release acceptance.

## Operation
- Tick divider:
  - Counts 0..CLK_HZ/SCAN_HZ-1 and asserts the internal tick for one cycle on the terminal count.
- Column counter:
  - 2-bit `col` increments on tick and wraps from 3 to 0.
  - keyCol decodes `col`: 0→1110, 1→1101, 2→1011, 3→0111.
- Row input:
  - keyRow passes through a 2-flop synchronizer before any use.
- Sampling:
  - On each tick, before `col` advances, the synchronized rows are sampled for the current column.
  - The first 0 bit found (lowest row) in the lowest column scanned so far in this scan is kept as the scan snapshot {hit, code}.
  - Later hits in the same scan are ignored. This gives priority to the lowest column, then the lowest row.
- Scan end:
  - Scan end is the tick where `col`==3. The col-3 sample is included in the snapshot.
  - The FSM then evaluates the snapshot, and the snapshot register clears for the next scan.
- FSM (evaluated only at scan end), states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE:
    - hit → PRESS_WAIT, with cand=code and cnt=1.
    - no hit → stay in IDLE.
  - PRESS_WAIT:
    - hit with code==cand → cnt+1. When cnt+1==DEBOUNCE_SCANS: go to PRESSED, latch keyCode=cand, pulse keyValid, set keyHeld=1.
    - hit with a different code → restart, with cand=code and cnt=1.
    - no hit → IDLE.
  - PRESSED:
    - any snapshot other than (hit with code==keyCode) → RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT:
    - no hit → cnt+1. When cnt+1==DEBOUNCE_SCANS: go to IDLE, clear keyHeld.
    - any hit → PRESSED. A different key held without a full release is never reported.
- keyCode holds its value after release until the next accepted press.
- Debounce counter width is $clog2(DEBOUNCE_SCANS+1). It never exceeds DEBOUNCE_SCANS.

## Timing
- Reset values, applied immediately on reset=0 regardless of clk:
  - keyCol=1110, keyCode=0, keyValid=0, keyHeld=0.
  - State IDLE, divider=0, col=0, snapshot and cnt cleared, synchronizer flops = 1111.
- Row settle: a column is driven for a full tick period before sampling. The synchronizer latency of 2 cycles fits inside this period because the divide ratio is >= 4.
- Press latency:
  - keyValid rises on the clock edge following the scan-end tick of the DEBOUNCE_SCANS-th consecutive matching scan.
  - keyHeld rises on the same edge as keyValid.
  - keyCode is valid on that edge and stays stable afterwards.
- keyValid is high for exactly one cycle per accepted press, never two in a row.
- Release latency: keyHeld falls on the clock edge after the scan-end tick of the DEBOUNCE_SCANS-th consecutive empty scan.
- Reset mid-operation:
  - All state is discarded.
  - A key still held when reset deasserts is reported as a fresh press after DEBOUNCE_SCANS scans.
- Reset deassertion is synchronized by the top level. The block needs no extra handling.

## Test plan
Settings: CLK_HZ/SCAN_HZ=4 (tick every 4 cycles, scan = 16 cycles), DEBOUNCE_SCANS=3. The keypad model drives keyRow low on a key's row only while that key's column is low.
- Reset and scan:
  - Stimulus: reset=0 for 5 cycles, then release, no key.
  - Required: keyCol=1110 during reset, then the sequence 1110, 1101, 1011, 0111 with 4 cycles per step; keyValid=0, keyHeld=0, keyCode=0 throughout.
- Clean press:
  - Stimulus: key at row 2, col 1 held for 10 scans.
  - Required: exactly one keyValid pulse, keyCode=9, keyHeld=1 from that pulse onward. The pulse arrives at the edge after the end of the 3rd full scan containing the key.
- Bounce rejection:
  - Stimulus: key at row 0, col 3 present 2 scans, absent 1, present 2, absent 5.
  - Required: no keyValid, keyHeld stays 0.
- Release debounce:
  - Stimulus: after the clean press, release; the key reappears for 1 scan after 1 empty scan; then stays released.
  - Required: keyHeld stays 1 through the glitch and falls only after 3 consecutive empty scans; no second keyValid.
- Multi-key priority:
  - Stimulus: keys (row 3, col 0) and (row 0, col 2) pressed together.
  - Required: a single keyValid with keyCode=12; no report for the second key until both are released and it is pressed again.
- Reset mid-press:
  - Stimulus: assert reset while keyHeld=1 with the key still held, then deassert.
  - Required: keyHeld=0 and keyCode=0 immediately; keyValid re-asserts with the same code after 3 scans.
